// File: rtl/matrix_pkg.sv
`default_nettype none
// ============================================================================
// Module      : matrix_pkg
// Description : Shared widths, FSM state encoding and element-extraction
//               helper for the matrix dot-product engine.
// Revision    : 1.0 - initial release
// ============================================================================
package matrix_pkg;

    // Element width and maximum matrix dimensions
    localparam int ELEM_W    = 8;
    localparam int MAX_N     = 32;   // inner dimension (A row / B column length)
    localparam int MAX_M     = 32;   // rows of A
    localparam int MAX_P     = 32;   // columns of B
    localparam int ACC_WIDTH = 2 * ELEM_W + $clog2(MAX_N);
    localparam int EIDX_W    = $clog2(MAX_N * ELEM_W);

    // FSM state encoding
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_REQ  = 3'd1;
    localparam state_t ST_WAIT = 3'd2;
    localparam state_t ST_MAC  = 3'd3;
    localparam state_t ST_EMIT = 3'd4;

    // Element e of a packed vector lives at bits [e*ELEM_W +: ELEM_W]
    function automatic logic [ELEM_W-1:0] get_elem(
        input logic [MAX_N*ELEM_W-1:0]  vec,
        input logic [$clog2(MAX_N)-1:0] e
    );
        logic [EIDX_W-1:0] base;
        base = EIDX_W'(e) * EIDX_W'(ELEM_W);
        return vec[base +: ELEM_W];
    endfunction

endpackage
`default_nettype wire

// File: rtl/matrix_dot_engine_mac_unit.sv
`default_nettype none
// ============================================================================
// Module      : mac_unit
// Description : Registered unsigned multiply-accumulator. Clear zeroes the
//               accumulator, enable adds a*b zero-extended to ACC_W.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_unit #(
    parameter int ELEM_W = 8,
    parameter int ACC_W  = 21
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_enable,
    input  logic [ELEM_W-1:0] i_a,
    input  logic [ELEM_W-1:0] i_b,
    output logic [ACC_W-1:0]  o_acc
);

    logic [2*ELEM_W-1:0] w_prod;
    logic [ACC_W-1:0]    r_acc;

    assign w_prod = i_a * i_b;
    assign o_acc  = r_acc;

    // Accumulator: clear has priority over accumulate
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
        end else if (i_enable) begin
            r_acc <= r_acc + ACC_W'(w_prod);
        end
    end

endmodule
`default_nettype wire

// File: rtl/matrix_dot_engine.sv
`default_nettype none
// ============================================================================
// Module      : matrix_dot_engine
// Description : Walks C = A*B one element at a time: requests an A row and
//               a B column, waits for the loader, MACs K pairs serially and
//               emits the result with its (row, col) index.
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_dot_engine
    import matrix_pkg::*;
#(
    parameter int MAX_ELEMENT_SIZE = ELEM_W,
    parameter int MAX_ROW_SIZE_A   = MAX_N,
    parameter int MAX_COL_SIZE_A   = MAX_M,
    parameter int MAX_COL_SIZE_B   = MAX_P,
    parameter int ACC_W            = 2 * MAX_ELEMENT_SIZE + $clog2(MAX_ROW_SIZE_A)
) (
    input  logic                                     inter_refclk,
    input  logic                                     rst,
    input  logic                                     start,
    input  logic [$clog2(MAX_COL_SIZE_A):0]          dim_m,
    input  logic [$clog2(MAX_ROW_SIZE_A):0]          dim_k,
    input  logic [$clog2(MAX_COL_SIZE_B):0]          dim_n,
    output logic                                     requested_a_row,
    output logic                                     requested_b_col,
    output logic [$clog2(MAX_COL_SIZE_A)-1:0]        a_idx,
    output logic [$clog2(MAX_COL_SIZE_B)-1:0]        b_idx,
    input  logic                                     complete,
    input  logic [MAX_ROW_SIZE_A*MAX_ELEMENT_SIZE-1:0] a_row_in,
    input  logic [MAX_ROW_SIZE_A*MAX_ELEMENT_SIZE-1:0] b_col_in,
    output logic [ACC_W-1:0]                         result_out,
    output logic                                     result_valid,
    output logic                                     busy,
    output logic                                     done
);

    localparam int N_W  = $clog2(MAX_ROW_SIZE_A);
    localparam int M_IW = $clog2(MAX_COL_SIZE_A);
    localparam int P_IW = $clog2(MAX_COL_SIZE_B);
    localparam int VEC_W = MAX_ROW_SIZE_A * MAX_ELEMENT_SIZE;
    localparam logic [N_W:0] c_K_MAX = (N_W+1)'(MAX_ROW_SIZE_A);

    state_t            r_state;
    logic [M_IW:0]     r_m;
    logic [N_W:0]      r_k;
    logic [P_IW:0]     r_n;
    logic [M_IW-1:0]   r_a_idx;
    logic [P_IW-1:0]   r_b_idx;
    logic [N_W-1:0]    r_e;
    logic [VEC_W-1:0]  r_a_vec;
    logic [VEC_W-1:0]  r_b_vec;
    logic              r_done;

    logic              w_latch;
    logic              w_mac_en;
    logic              w_last_e;
    logic              w_last_col;
    logic              w_last_row;
    logic [ACC_W-1:0]  w_acc;

    assign w_latch    = (r_state == ST_WAIT) && complete;
    assign w_mac_en   = (r_state == ST_MAC);
    assign w_last_e   = ({1'b0, r_e} == r_k - 1'b1);
    assign w_last_col = ({1'b0, r_b_idx} == r_n - 1'b1);
    assign w_last_row = ({1'b0, r_a_idx} == r_m - 1'b1);

    assign requested_a_row = (r_state == ST_REQ);
    assign requested_b_col = (r_state == ST_REQ);
    assign result_valid    = (r_state == ST_EMIT);
    assign busy            = (r_state != ST_IDLE);
    assign done            = r_done;
    assign a_idx           = r_a_idx;
    assign b_idx           = r_b_idx;
    assign result_out      = w_acc;

    mac_unit #(
        .ELEM_W (MAX_ELEMENT_SIZE),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk      (inter_refclk),
        .rst      (rst),
        .i_clear  (w_latch),
        .i_enable (w_mac_en),
        .i_a      (get_elem(r_a_vec, r_e)),
        .i_b      (get_elem(r_b_vec, r_e)),
        .o_acc    (w_acc)
    );

    // Sequencer: dims latch, request/wait/MAC/emit loop and index walk
    always_ff @(posedge inter_refclk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_m     <= '0;
            r_k     <= '0;
            r_n     <= '0;
            r_a_idx <= '0;
            r_b_idx <= '0;
            r_e     <= '0;
            r_a_vec <= '0;
            r_b_vec <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_m <= dim_m;
                        r_n <= dim_n;
                        r_k <= (dim_k > c_K_MAX) ? c_K_MAX : dim_k;
                        if (dim_m == '0 || dim_k == '0 || dim_n == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_a_idx <= '0;
                            r_b_idx <= '0;
                            r_state <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    // complete is deliberately ignored here: it may still be
                    // high from the previous element's transfer
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (complete) begin
                        r_a_vec <= a_row_in;
                        r_b_vec <= b_col_in;
                        r_e     <= '0;
                        r_state <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    r_e <= r_e + 1'b1;
                    if (w_last_e) begin
                        r_state <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (w_last_col) begin
                        r_b_idx <= '0;
                        if (w_last_row) begin
                            r_a_idx <= '0;
                            r_done  <= 1'b1;
                            r_state <= ST_IDLE;
                        end else begin
                            r_a_idx <= r_a_idx + 1'b1;
                            r_state <= ST_REQ;
                        end
                    end else begin
                        r_b_idx <= r_b_idx + 1'b1;
                        r_state <= ST_REQ;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_matrix_dot_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_matrix_dot_engine
// Description : Self-checking bench for matrix_dot_engine with a behavioural
//               loader and a scoreboard of expected (row, col, value).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_dot_engine;

    typedef struct {
        int r;
        int c;
        int v;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          start;
    logic [5:0]    dim_m;
    logic [5:0]    dim_k;
    logic [5:0]    dim_n;
    logic          requested_a_row;
    logic          requested_b_col;
    logic [4:0]    a_idx;
    logic [4:0]    b_idx;
    logic          complete;
    logic [255:0]  a_row_in;
    logic [255:0]  b_col_in;
    logic [20:0]   result_out;
    logic          result_valid;
    logic          busy;
    logic          done;

    logic [7:0] mat_a [32][32];
    logic [7:0] mat_b [32][32];
    exp_t       sb_q[$];

    int cyc         = 0;
    int checks      = 0;
    int errors      = 0;
    int n_req       = 0;
    int n_res       = 0;
    int cur_k       = 0;
    int cur_wait    = 0;
    int req_cyc     = -1;
    int prev_rv_cyc = -1;
    int last_rv_cyc = -1;

    matrix_dot_engine dut (
        .inter_refclk    (clk),
        .rst             (rst),
        .start           (start),
        .dim_m           (dim_m),
        .dim_k           (dim_k),
        .dim_n           (dim_n),
        .requested_a_row (requested_a_row),
        .requested_b_col (requested_b_col),
        .a_idx           (a_idx),
        .b_idx           (b_idx),
        .complete        (complete),
        .a_row_in        (a_row_in),
        .b_col_in        (b_col_in),
        .result_out      (result_out),
        .result_valid    (result_valid),
        .busy            (busy),
        .done            (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Loader model: leaves stale complete/data up during the request cycle,
    // then drops complete for cur_wait cycles before presenting fresh data.
    initial begin
        int ri;
        int ci;
        complete = 1'b0;
        a_row_in = '0;
        b_col_in = '0;
        forever begin
            @(negedge clk);
            if (requested_a_row && !rst) begin
                ri = int'(a_idx);
                ci = int'(b_idx);
                if (cur_wait > 0) begin
                    @(negedge clk);
                    complete = 1'b0;
                    repeat (cur_wait) @(negedge clk);
                end
                for (int e = 0; e < 32; e++) begin
                    a_row_in[e*8 +: 8] = mat_a[ri][e];
                    b_col_in[e*8 +: 8] = mat_b[e][ci];
                end
                complete = 1'b1;
            end
        end
    end

    // Scoreboard monitor and protocol invariants
    initial forever begin
        exp_t ex;
        @(negedge clk);
        if (requested_a_row) begin
            n_req++;
            req_cyc = cyc;
        end
        if (result_valid) begin
            n_res++;
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result got (%0d,%0d)=%0d required none", a_idx, b_idx, result_out);
            end else begin
                ex = sb_q.pop_front();
                if ({27'd0, a_idx} !== ex.r || {27'd0, b_idx} !== ex.c || {11'd0, result_out} !== ex.v) begin
                    errors++;
                    $display("FAIL result got (%0d,%0d)=%0d required (%0d,%0d)=%0d",
                             a_idx, b_idx, result_out, ex.r, ex.c, ex.v);
                end
            end
            checks++;
            if (cyc - req_cyc !== cur_k + cur_wait + 2) begin
                errors++;
                $display("FAIL req_to_result_latency got %0d required %0d", cyc - req_cyc, cur_k + cur_wait + 2);
            end
            if (prev_rv_cyc >= 0) begin
                checks++;
                if (cyc - prev_rv_cyc !== cur_k + cur_wait + 3) begin
                    errors++;
                    $display("FAIL result_spacing got %0d required %0d", cyc - prev_rv_cyc, cur_k + cur_wait + 3);
                end
            end
            prev_rv_cyc = cyc;
            last_rv_cyc = cyc;
        end
        if (result_valid && done) begin
            checks++;
            errors++;
            $display("FAIL valid_done_overlap got 1 required 0");
        end
        if ((requested_a_row || requested_b_col) && result_valid) begin
            checks++;
            errors++;
            $display("FAIL request_result_overlap got 1 required 0");
        end
        if (requested_a_row !== requested_b_col) begin
            checks++;
            errors++;
            $display("FAIL request_pair got a=%0b b=%0b required equal", requested_a_row, requested_b_col);
        end
    end

    task automatic fill_random();
        for (int i = 0; i < 32; i++) begin
            for (int j = 0; j < 32; j++) begin
                mat_a[i][j] = 8'($urandom_range(0, 255));
                mat_b[i][j] = 8'($urandom_range(0, 255));
            end
        end
    endtask

    task automatic push_expected(input int m, input int k, input int n);
        exp_t ex;
        int   kk;
        kk = (k > 32) ? 32 : k;
        for (int i = 0; i < m; i++) begin
            for (int j = 0; j < n; j++) begin
                ex.r = i;
                ex.c = j;
                ex.v = 0;
                for (int e = 0; e < kk; e++) begin
                    ex.v += int'(mat_a[i][e]) * int'(mat_b[e][j]);
                end
                sb_q.push_back(ex);
            end
        end
    endtask

    task automatic do_start(input int m, input int k, input int n, input int w);
        @(negedge clk);
        cur_k       = (k > 32) ? 32 : k;
        cur_wait    = w;
        prev_rv_cyc = -1;
        dim_m = 6'(m);
        dim_k = 6'(k);
        dim_n = 6'(n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int dcyc);
        dcyc = -1;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                dcyc = cyc;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        dim_m = '0;
        dim_k = '0;
        dim_n = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got busy=%0b done=%0b rv=%0b required 0", busy, done, result_valid);
        end
        checks++;
        if (requested_a_row !== 1'b0 || requested_b_col !== 1'b0) begin
            errors++;
            $display("FAIL reset_requests got %0b%0b required 00", requested_a_row, requested_b_col);
        end
        checks++;
        if (a_idx !== 5'd0 || b_idx !== 5'd0 || result_out !== 21'd0) begin
            errors++;
            $display("FAIL reset_data got a=%0d b=%0d r=%0d required 0", a_idx, b_idx, result_out);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_identity();
        int r0, q0, dcyc;
        fill_random();
        mat_a[0][0] = 8'd1; mat_a[0][1] = 8'd0;
        mat_a[1][0] = 8'd0; mat_a[1][1] = 8'd1;
        mat_b[0][0] = 8'd5; mat_b[0][1] = 8'd6;
        mat_b[1][0] = 8'd7; mat_b[1][1] = 8'd8;
        r0 = n_res; q0 = n_req;
        push_expected(2, 2, 2);
        do_start(2, 2, 2, 0);
        wait_done(500, dcyc);
        checks++;
        if (dcyc < 0) begin
            errors++;
            $display("FAIL identity_timeout got no done required done");
        end
        checks++;
        if (dcyc !== last_rv_cyc + 1) begin
            errors++;
            $display("FAIL identity_done_timing got %0d required %0d", dcyc, last_rv_cyc + 1);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL identity_busy_at_done got %0b required 0", busy);
        end
        checks++;
        if (n_req - q0 !== 4 || n_res - r0 !== 4) begin
            errors++;
            $display("FAIL identity_counts got req=%0d res=%0d required 4 4", n_req - q0, n_res - r0);
        end
        checks++;
        if (sb_q.size() !== 0) begin
            errors++;
            $display("FAIL identity_leftover got %0d required 0", sb_q.size());
        end
        @(negedge clk);
    endtask

    task automatic test_max_value();
        int dcyc;
        for (int i = 0; i < 32; i++) begin
            for (int j = 0; j < 32; j++) begin
                mat_a[i][j] = 8'hFF;
                mat_b[i][j] = 8'hFF;
            end
        end
        push_expected(1, 32, 2);
        do_start(1, 32, 2, 0);
        wait_done(500, dcyc);
        // dim_k above N clamps to N
        push_expected(1, 40, 1);
        do_start(1, 40, 1, 0);
        wait_done(500, dcyc);
        checks++;
        if (dcyc < 0 || sb_q.size() !== 0) begin
            errors++;
            $display("FAIL max_value_completion got done_cyc=%0d left=%0d required done and 0", dcyc, sb_q.size());
        end
        @(negedge clk);
    endtask

    task automatic test_loader_delay();
        int r0, dcyc;
        fill_random();
        r0 = n_res;
        push_expected(2, 5, 3);
        do_start(2, 5, 3, 7);
        wait_done(2000, dcyc);
        checks++;
        if (dcyc < 0 || n_res - r0 !== 6 || sb_q.size() !== 0) begin
            errors++;
            $display("FAIL loader_delay got done_cyc=%0d res=%0d left=%0d required done 6 0",
                     dcyc, n_res - r0, sb_q.size());
        end
        cur_wait = 0;
        @(negedge clk);
    endtask

    task automatic test_zero_dims();
        int q0, r0;
        int dm [3] = '{1, 0, 2};
        int dk [3] = '{0, 3, 3};
        int dn [3] = '{2, 2, 0};
        for (int t = 0; t < 3; t++) begin
            q0 = n_req; r0 = n_res;
            do_start(dm[t], dk[t], dn[t], 0);
            checks++;
            if (done !== 1'b1) begin
                errors++;
                $display("FAIL zero_dim_done case %0d got %0b required 1", t, done);
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL zero_dim_pulse case %0d got done=%0b busy=%0b required 0 0", t, done, busy);
            end
            repeat (5) @(negedge clk);
            checks++;
            if (n_req !== q0 || n_res !== r0) begin
                errors++;
                $display("FAIL zero_dim_activity case %0d got req=%0d res=%0d required none", t, n_req - q0, n_res - r0);
            end
        end
    endtask

    task automatic test_reset_mid_mac();
        int guard, dcyc;
        fill_random();
        push_expected(2, 8, 2);
        do_start(2, 8, 2, 0);
        guard = 0;
        while (!requested_a_row && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (guard >= 50) begin
            errors++;
            $display("FAIL reset_mid_mac_no_request got none required request");
        end
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || result_out !== 21'd0 || a_idx !== 5'd0 || b_idx !== 5'd0 || result_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_mac_outputs got busy=%0b r=%0d a=%0d b=%0d rv=%0b required 0",
                     busy, result_out, a_idx, b_idx, result_valid);
        end
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        fill_random();
        push_expected(2, 6, 2);
        do_start(2, 6, 2, 0);
        wait_done(1000, dcyc);
        checks++;
        if (dcyc < 0 || sb_q.size() !== 0) begin
            errors++;
            $display("FAIL reset_mid_mac_rerun got done_cyc=%0d left=%0d required done 0", dcyc, sb_q.size());
        end
        @(negedge clk);
    endtask

    task automatic test_start_while_busy();
        int q0, r0, dcyc, extra_done;
        fill_random();
        q0 = n_req; r0 = n_res;
        push_expected(2, 3, 2);
        do_start(2, 3, 2, 0);
        repeat (4) @(negedge clk);
        dim_m = 6'd3; dim_k = 6'd9; dim_n = 6'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(1000, dcyc);
        checks++;
        if (dcyc < 0 || n_res - r0 !== 4 || n_req - q0 !== 4 || sb_q.size() !== 0) begin
            errors++;
            $display("FAIL start_while_busy got done_cyc=%0d res=%0d req=%0d left=%0d required done 4 4 0",
                     dcyc, n_res - r0, n_req - q0, sb_q.size());
        end
        extra_done = 0;
        repeat (20) begin
            @(negedge clk);
            if (done || busy) extra_done++;
        end
        checks++;
        if (extra_done !== 0 || n_res - r0 !== 4) begin
            errors++;
            $display("FAIL start_while_busy_tail got activity=%0d res=%0d required 0 4", extra_done, n_res - r0);
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_max_value();
        test_loader_delay();
        test_zero_dims();
        test_reset_mid_mac();
        test_start_while_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
